// File: rtl/sd_fifo_buffer.sv
// Single-clock FIFO for the SD host data path: registered 1-cycle read,
// count-based full/empty, threshold flags, flush and sticky error flags.
module sd_fifo_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 7,
  parameter int AF_THRESH  = 2**ADDR_WIDTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  typedef logic [ADDR_WIDTH:0] cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
  localparam cnt_t AF_C    = cnt_t'(AF_THRESH);
  localparam cnt_t AE_C    = cnt_t'(AE_THRESH);

  // Thresholds outside AE < AF <= DEPTH make the flags meaningless.
  if (!((AE_THRESH >= 0) && (AE_THRESH < AF_THRESH) && (AF_THRESH <= DEPTH))) begin : g_bad_cfg
    $error("sd_fifo_buffer: illegal thresholds, need 0 <= AE_THRESH < AF_THRESH <= DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  rd_acc;
  logic                  wr_acc;
  cnt_t                  count_nxt;

  function automatic cnt_t next_count(input cnt_t c, input logic wr, input logic rd);
    case ({wr, rd})
      2'b10:   return c + cnt_t'(1);
      2'b01:   return c - cnt_t'(1);
      default: return c;
    endcase
  endfunction

  // Accept decisions use the registered flags; a full FIFO still takes a
  // write when a read frees a slot on the same edge.
  always_comb begin
    rd_acc    = rd_en & ~empty;
    wr_acc    = wr_en & (~full | rd_acc);
    count_nxt = flush ? '0 : next_count(count, wr_acc, rd_acc);
  end

  // Storage is never reset; flush leaves contents in place.
  always_ff @(posedge clk) begin
    if (wr_acc && !flush) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // ---- stage p0 -> p1: pointers, count, flags, read register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= (AF_C == '0);
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      rd_valid     <= 1'b0;
      data_out     <= '0;
    end else begin
      count        <= count_nxt;
      full         <= (count_nxt == DEPTH_C);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF_C);
      almost_empty <= (count_nxt <= AE_C);
      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
        rd_valid  <= 1'b0;
      end else begin
        if (wr_acc) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (rd_acc) begin
          rd_ptr   <= rd_ptr + 1'b1;
          data_out <= mem[rd_ptr];
        end
        rd_valid  <= rd_acc;
        overflow  <= overflow  | (wr_en & ~wr_acc);
        underflow <= underflow | (rd_en & empty);
      end
    end
  end

endmodule

// File: tb/tb_sd_fifo_buffer.sv
// Bench for sd_fifo_buffer: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based model.
module tb_sd_fifo_buffer;

  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          wr_en;
  logic [DW-1:0] data_in;
  logic          rd_en;
  logic [DW-1:0] data_out;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  int n_vec = 0;
  int n_err = 0;

  sd_fifo_buffer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .wr_en       (wr_en),
    .data_in     (data_in),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a queue of stored words plus the visible read word.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic          m_vld;
  logic          m_ovf;
  logic          m_udf;
  bit            m_ra;
  bit            m_wa;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_dout = '0;
      m_vld  = 1'b0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else if (flush) begin
      q.delete();
      m_vld = 1'b0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      m_ra = rd_en && (q.size() > 0);
      m_wa = wr_en && ((q.size() < DEPTH) || m_ra);
      if (rd_en && q.size() == 0) m_udf = 1'b1;
      if (wr_en && !m_wa)         m_ovf = 1'b1;
      if (m_ra) begin
        m_dout = q.pop_front();
        m_vld  = 1'b1;
      end else begin
        m_vld = 1'b0;
      end
      if (m_wa) q.push_back(data_in);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      chk("data_out",     data_out,     m_dout);
      chk("rd_valid",     rd_valid,     m_vld);
      chk("count",        count,        q.size());
      chk("full",         full,         q.size() == DEPTH);
      chk("empty",        empty,        q.size() == 0);
      chk("almost_full",  almost_full,  q.size() >= AF);
      chk("almost_empty", almost_empty, q.size() <= AE);
      chk("overflow",     overflow,     m_ovf);
      chk("underflow",    underflow,    m_udf);
    end
  end

  task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
    wr_en   = w;
    data_in = d;
    rd_en   = r;
    flush   = f;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
  endtask

  logic [DW-1:0] drain_exp [8];
  logic [DW-1:0] saved;

  initial begin
    reset   = 1'b1;
    flush   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = '0;
    drain_exp = '{16'h1001, 16'h1002, 16'h1003, 16'h1004,
                  16'h1005, 16'h1006, 16'h1007, 16'hBEEF};
    repeat (2) @(negedge clk);
    chk("rst_empty", empty, 1);
    chk("rst_ae",    almost_empty, 1);
    chk("rst_full",  full, 0);
    chk("rst_af",    almost_full, 0);
    chk("rst_count", count, 0);
    chk("rst_dout",  data_out, 16'h0000);
    chk("rst_vld",   rd_valid, 0);
    reset = 1'b0;
    @(negedge clk);

    // Fill
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0);
      chk("fill_af", almost_full,  (i + 1) >= 6);
      chk("fill_ae", almost_empty, (i + 1) <= 2);
    end
    chk("fill_count", count, 8);
    chk("fill_full",  full, 1);

    // Read and write together while full
    step(1'b1, 16'hBEEF, 1'b1, 1'b0);
    chk("simfull_dout",  data_out, 16'h1000);
    chk("simfull_vld",   rd_valid, 1);
    chk("simfull_count", count, 8);
    chk("simfull_ovf",   overflow, 0);

    // Write while full is dropped
    step(1'b1, 16'hDEAD, 1'b0, 1'b0);
    chk("ovf_flag",  overflow, 1);
    chk("ovf_count", count, 8);

    // Drain
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      chk("drain_dout", data_out, drain_exp[i]);
      chk("drain_vld",  rd_valid, 1);
    end
    chk("drain_empty", empty, 1);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("idle_vld",  rd_valid, 0);
    chk("idle_hold", data_out, 16'hBEEF);

    // Underflow, then write+read while empty
    step(1'b0, '0, 1'b1, 1'b0);
    chk("udf_flag", underflow, 1);
    chk("udf_vld",  rd_valid, 0);
    chk("udf_ovf_sticky", overflow, 1);
    step(1'b1, 16'h2222, 1'b1, 1'b0);
    chk("simempty_count", count, 1);
    chk("simempty_vld",   rd_valid, 0);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("flush1_ovf",   overflow, 0);
    chk("flush1_udf",   underflow, 0);
    chk("flush1_count", count, 0);

    // Wrap-around with steady occupancy of 3
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 16'h3000 + 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 16'h3003 + 16'(i), 1'b1, 1'b0);
      chk("wrap_dout",  data_out, 16'h3000 + 16'(i));
      chk("wrap_count", count, 3);
    end

    // Flush with simultaneous write and read
    step(1'b1, 16'h3100, 1'b0, 1'b0);
    step(1'b1, 16'h3101, 1'b0, 1'b0);
    chk("preflush_count", count, 5);
    saved = data_out;
    step(1'b1, 16'h5555, 1'b1, 1'b1);
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_vld",   rd_valid, 0);
    chk("flush_dout",  data_out, saved);
    chk("flush_udf",   underflow, 0);
    chk("flush_ovf",   overflow, 0);
    step(1'b1, 16'h4444, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("postflush_dout", data_out, 16'h4444);
    chk("postflush_vld",  rd_valid, 1);

    // Asynchronous reset mid-burst
    step(1'b1, 16'h6000, 1'b0, 1'b0);
    wr_en   = 1'b1;
    data_in = 16'h6001;
    rd_en   = 1'b1;
    @(posedge clk);
    #3;
    chk("burst_vld", rd_valid, 1);
    reset = 1'b1;
    #1;
    chk("arst_empty", empty, 1);
    chk("arst_ae",    almost_empty, 1);
    chk("arst_full",  full, 0);
    chk("arst_count", count, 0);
    chk("arst_dout",  data_out, 16'h0000);
    chk("arst_vld",   rd_valid, 0);
    wr_en = 1'b0;
    rd_en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Random traffic, alternating bias between filling and draining
    for (int i = 0; i < 2000; i++) begin
      int wp;
      wp = ((i / 150) % 2 == 0) ? 75 : 25;
      step($urandom_range(99) < wp, 16'($urandom), $urandom_range(99) < (100 - wp),
           $urandom_range(199) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
